// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined, handshaked RV32M multiplier (MUL/MULH/MULHSU/MULHU) built on a dadda or wallace carry-save tree.
// Optional performance counters (perf_ops_o, perf_stall_o) are built when MUL_PERF_CNT_EN is defined.
module mul_pipe_unit #(
    parameter int XLEN     = 32,
    parameter int STAGES   = 2,
    parameter int TREE_TYP = 0,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
`ifdef MUL_PERF_CNT_EN
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_stall_o,
`endif
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULH  = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b11;
    localparam int         PW       = 2 * XLEN;
    localparam int         MAX_LVL  = 16;

    typedef logic [PW-1:0] row_t;

    typedef struct packed {
        row_t sum;
        row_t carry;
    } cs_t;

    // Reduces the XLEN partial-product rows to a sum/carry pair with 3:2 compressors.
    // Dadda compresses only enough rows per level to reach the next height in 2,3,4,6,9,...;
    // wallace compresses every complete group of three rows per level.
    function automatic cs_t cs_tree(input logic [XLEN-1:0] ma, input logic [XLEN-1:0] mb);
        row_t rows [XLEN];
        row_t nxt  [XLEN];
        int   h;
        int   tgt;
        int   n_csa;
        cs_t  res;
        for (int i = 0; i < XLEN; i++) begin
            rows[i] = mb[i] ? (row_t'(ma) << i) : '0;
        end
        h = XLEN;
        for (int lvl = 0; lvl < MAX_LVL; lvl++) begin
            if (h > 2) begin
                if (TREE_TYP == 0) begin
                    tgt = 2;
                    for (int j = 0; j < MAX_LVL; j++) begin
                        if ((tgt * 3) / 2 < h) tgt = (tgt * 3) / 2;
                    end
                    n_csa = h - tgt;
                end else begin
                    n_csa = h / 3;
                end
                for (int i = 0; i < XLEN; i++) begin
                    nxt[i] = '0;
                end
                for (int k = 0; k < XLEN / 3; k++) begin
                    if (k < n_csa) begin
                        nxt[2*k]   = rows[3*k] ^ rows[3*k+1] ^ rows[3*k+2];
                        nxt[2*k+1] = ((rows[3*k] & rows[3*k+1]) |
                                      (rows[3*k] & rows[3*k+2]) |
                                      (rows[3*k+1] & rows[3*k+2])) << 1;
                    end
                end
                // Rows not consumed by a compressor slide down behind the new sum/carry pairs.
                for (int i = 0; i < XLEN; i++) begin
                    if (i >= 2 * n_csa && i < h - n_csa) nxt[i] = rows[i + n_csa];
                end
                rows = nxt;
                h    = h - n_csa;
            end
        end
        res.sum   = rows[0];
        res.carry = rows[1];
        return res;
    endfunction

    logic             advance;
    logic             accept;
    logic             sign_a_in;
    logic             sign_b_in;
    logic             neg_in;
    logic             hi_in;
    logic [XLEN-1:0]  mag_a_in;
    logic [XLEN-1:0]  mag_b_in;

    logic             f_valid;
    logic             f_neg;
    logic             f_hi;
    logic [XLEN-1:0]  f_mag_a;
    logic [XLEN-1:0]  f_mag_b;
    logic [TAG_W-1:0] f_tag;
    cs_t              f_cs;

    logic             t_valid;
    logic             t_neg;
    logic             t_hi;
    row_t             t_sum;
    row_t             t_carry;
    logic [TAG_W-1:0] t_tag;
    row_t             t_abs;

    logic             p_valid;
    logic             p_neg;
    logic             p_hi;
    row_t             p_abs;
    logic [TAG_W-1:0] p_tag;

    row_t             prod;
    logic [XLEN-1:0]  sel;

    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    // NOTE: every variable is assigned on every path through an always_comb, so no latch can be inferred.
    always_comb begin
        sign_a_in = (op_i != OP_MULHU) & a_i[XLEN-1];
        sign_b_in = ((op_i == OP_MUL) | (op_i == OP_MULH)) & b_i[XLEN-1];
        mag_a_in  = sign_a_in ? (~a_i + XLEN'(1)) : a_i;
        mag_b_in  = sign_b_in ? (~b_i + XLEN'(1)) : b_i;
        neg_in    = sign_a_in ^ sign_b_in;
        hi_in     = (op_i != OP_MUL);
    end

    generate
        if (STAGES >= 2) begin : g_front_reg
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk_i) begin
                if (!rst_ni)      f_valid <= 1'b0;
                else if (flush_i) f_valid <= 1'b0;
                else if (advance) f_valid <= accept;
            end
            // NOTE: data registers carry no reset; they are only meaningful when their valid bit is set.
            always_ff @(posedge clk_i) begin
                if (advance) begin
                    f_mag_a <= mag_a_in;
                    f_mag_b <= mag_b_in;
                    f_neg   <= neg_in;
                    f_hi    <= hi_in;
                    f_tag   <= tag_i;
                end
            end
        end else begin : g_front_comb
            assign f_valid = accept;
            assign f_mag_a = mag_a_in;
            assign f_mag_b = mag_b_in;
            assign f_neg   = neg_in;
            assign f_hi    = hi_in;
            assign f_tag   = tag_i;
        end
    endgenerate

    assign f_cs = cs_tree(f_mag_a, f_mag_b);

    generate
        if (STAGES >= 3) begin : g_tree_reg
            always_ff @(posedge clk_i) begin
                if (!rst_ni)      t_valid <= 1'b0;
                else if (flush_i) t_valid <= 1'b0;
                else if (advance) t_valid <= f_valid;
            end
            always_ff @(posedge clk_i) begin
                if (advance) begin
                    t_sum   <= f_cs.sum;
                    t_carry <= f_cs.carry;
                    t_neg   <= f_neg;
                    t_hi    <= f_hi;
                    t_tag   <= f_tag;
                end
            end
        end else begin : g_tree_comb
            assign t_valid = f_valid;
            assign t_sum   = f_cs.sum;
            assign t_carry = f_cs.carry;
            assign t_neg   = f_neg;
            assign t_hi    = f_hi;
            assign t_tag   = f_tag;
        end
    endgenerate

    assign t_abs = t_sum + t_carry;

    generate
        if (STAGES >= 4) begin : g_add_reg
            always_ff @(posedge clk_i) begin
                if (!rst_ni)      p_valid <= 1'b0;
                else if (flush_i) p_valid <= 1'b0;
                else if (advance) p_valid <= t_valid;
            end
            always_ff @(posedge clk_i) begin
                if (advance) begin
                    p_abs <= t_abs;
                    p_neg <= t_neg;
                    p_hi  <= t_hi;
                    p_tag <= t_tag;
                end
            end
        end else begin : g_add_comb
            assign p_valid = t_valid;
            assign p_abs   = t_abs;
            assign p_neg   = t_neg;
            assign p_hi    = t_hi;
            assign p_tag   = t_tag;
        end
    endgenerate

    always_comb begin
        prod = p_neg ? (~p_abs + row_t'(1)) : p_abs;
        sel  = p_hi ? prod[PW-1:XLEN] : prod[XLEN-1:0];
    end

    // Output register: frozen while the consumer stalls, so result_o/tag_o stay stable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            tag_o       <= '0;
        end else begin
            if (flush_i)      out_valid_o <= 1'b0;
            else if (advance) out_valid_o <= p_valid;
            if (advance) begin
                result_o <= sel;
                tag_o    <= p_tag;
            end
        end
    end

`ifdef MUL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_ops_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (out_valid_o & out_ready_i)  perf_ops_o   <= perf_ops_o + 32'd1;
            if (out_valid_o & ~out_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Self-checking bench for mul_pipe_unit: four configurations driven in lockstep, each checked by an in-order
// queue model; directed table vectors, backpressure, flush and reset sequences run on the default instance.
module tb_mul_pipe_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int NDUT  = 4;
    localparam int STG0  = 2;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;

    logic             in_ready_v  [NDUT];
    logic             out_valid_v [NDUT];
    logic [XLEN-1:0]  result_v    [NDUT];
    logic [TAG_W-1:0] tag_v       [NDUT];
`ifdef MUL_PERF_CNT_EN
    logic [31:0]      perf_ops_v   [NDUT];
    logic [31:0]      perf_stall_v [NDUT];
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc [NDUT];
    exp_t sb_q  [NDUT][$];

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: wallace; 2: single stage; 3: four stages with wallace.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mul_pipe_unit #(
            .XLEN    (XLEN),
            .STAGES  ((g == 2) ? 1 : ((g == 3) ? 4 : 2)),
            .TREE_TYP((g == 1 || g == 3) ? 1 : 0),
            .TAG_W   (TAG_W)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .flush_i     (flush),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready_v[g]),
            .op_i        (op),
            .a_i         (a),
            .b_i         (b),
            .tag_i       (tag),
            .out_valid_o (out_valid_v[g]),
            .out_ready_i (out_ready),
            .result_o    (result_v[g]),
`ifdef MUL_PERF_CNT_EN
            .perf_ops_o  (perf_ops_v[g]),
            .perf_stall_o(perf_stall_v[g]),
`endif
            .tag_o       (tag_v[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-precision signed/unsigned product, then the requested half.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = (o != 2'b11) ? longint'($signed(x)) : longint'({32'b0, x});
        sy = (o == 2'b00 || o == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
        p  = 64'(sx * sy);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: outputs must leave in acceptance order; flush and reset discard everything in flight.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (out_valid_v[k] === 1'b1 && out_ready === 1'b1) begin
                if (sb_q[k].size() == 0) begin
                    check($sformatf("spurious_out_dut%0d", k), 64'(out_valid_v[k]), 64'd0);
                end else begin
                    e = sb_q[k].pop_front();
                    check($sformatf("sb_result_dut%0d", k), 64'(result_v[k]), 64'(e.res));
                    check($sformatf("sb_tag_dut%0d", k), 64'(tag_v[k]), 64'(e.tag));
                end
            end
            if (rst_n !== 1'b1 || flush === 1'b1) begin
                sb_q[k].delete();
            end else if (in_valid === 1'b1 && in_ready_v[k] === 1'b1) begin
                sb_q[k].push_back('{res: ref_mul(op, a, b), tag: tag});
                n_acc[k]++;
            end
        end
    end

    // One op on instance 0 with an idle pipe: exact latency, value and tag.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input logic [31:0] expv);
        @(posedge clk); #1;
        op = o; a = x; b = y; tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready_v[0]), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= STG0; c++) begin
            @(negedge clk);
            if (c < STG0) check({name, "_early_valid"}, 64'(out_valid_v[0]), 64'd0);
        end
        check({name, "_valid"}, 64'(out_valid_v[0]), 64'd1);
        check({name, "_result"}, 64'(result_v[0]), 64'(expv));
        check({name, "_tag"}, 64'(tag_v[0]), 64'(t));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs [13];
        logic [1:0]  bp_op  [4];
        logic [31:0] bp_a   [4];
        logic [31:0] bp_b   [4];
        logic [31:0] bp_exp [4];
        int          sent;
        int          got;
        int          base;
`ifdef MUL_PERF_CNT_EN
        logic [31:0] ops0;
        logic [31:0] stall0;
`endif

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
        vecs[8]  = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[9]  = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
        vecs[10] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[11] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[12] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};

        bp_op = '{2'b00, 2'b01, 2'b10, 2'b11};
        bp_a  = '{32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFF0, 32'hDEAD_BEEF};
        bp_b  = '{32'h0000_0010, 32'h7FFF_FFFF, 32'h0000_0100, 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) bp_exp[i] = ref_mul(bp_op[i], bp_a[i], bp_b[i]);
        for (int k = 0; k < NDUT; k++) n_acc[k] = 0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; a = '0; b = '0; tag = '0;

        // Reset state of every instance.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset_valid_dut%0d", k), 64'(out_valid_v[k]), 64'd0);
            check($sformatf("reset_result_dut%0d", k), 64'(result_v[k]), 64'd0);
            check($sformatf("reset_tag_dut%0d", k), 64'(tag_v[k]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
        end

        // Backpressure: consumer stalls for 5 cycles while 4 ops stream in.
`ifdef MUL_PERF_CNT_EN
        ops0   = perf_ops_v[0];
        stall0 = perf_stall_v[0];
`endif
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            in_valid  = (sent < 4);
            op        = bp_op[sent % 4];
            a         = bp_a[sent % 4];
            b         = bp_b[sent % 4];
            tag       = 5'(sent + 16);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 4) check("bp_in_ready_full", 64'(in_ready_v[0]), 64'd0);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_hold_valid", 64'(out_valid_v[0]), 64'd1);
                check("bp_hold_result", 64'(result_v[0]), 64'(bp_exp[0]));
            end
            if (out_valid_v[0] && out_ready) begin
                check("bp_order_result", 64'(result_v[0]), 64'(bp_exp[got % 4]));
                check("bp_order_tag", 64'(tag_v[0]), 64'(got + 16));
                check("bp_pop_cycle", 64'(cyc), 64'(5 + got));
                got++;
            end
            if (in_valid && in_ready_v[0]) sent++;
        end
        check("bp_count", 64'(got), 64'd4);
`ifdef MUL_PERF_CNT_EN
        check("perf_ops_delta", 64'(perf_ops_v[0] - ops0), 64'd4);
        check("perf_stall_delta", 64'(perf_stall_v[0] - stall0), 64'd3);
`endif

        // Flush with two ops in flight and a new request in the flush cycle.
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; tag = 5'd1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd4; tag = 5'd2;
        @(posedge clk); #1;
        flush = 1'b1; a = 32'd9; tag = 5'd3;
        @(negedge clk);
        check("flush_busy_out_valid", 64'(out_valid_v[0]), 64'd1);
        check("flush_busy_in_ready", 64'(in_ready_v[0]), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_killed_valid", 64'(out_valid_v[0]), 64'd0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; a = 32'd10; tag = 5'd4;
        @(negedge clk);
        check("flush_idle_in_ready", 64'(in_ready_v[0]), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("flush_no_out", 64'(out_valid_v[0]), 64'd0);
        end
        do_op("post_flush", 2'b11, 32'hFFFF_0000, 32'h0001_0000, 5'd7, 32'h0000_FFFF);

        // Reset with ops in flight and a held, non-zero output.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9; tag = 5'd5;
        @(posedge clk); #1;
        a = 32'd11; tag = 5'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid_v[0]), 64'd1);
        check("pre_reset_result", 64'(result_v[0]), 64'd63);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("mid_reset_valid_dut%0d", k), 64'(out_valid_v[k]), 64'd0);
            check($sformatf("mid_reset_result_dut%0d", k), 64'(result_v[k]), 64'd0);
            check($sformatf("mid_reset_tag_dut%0d", k), 64'(tag_v[k]), 64'd0);
        end
        out_ready = 1'b1;
        do_op("post_reset", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9, 32'hFFFF_FFFF);

        // Random traffic on all instances with stalls, rare flushes and one reset pulse.
        base = n_acc[0];
        for (int cyc = 0; cyc < 40000 && (n_acc[0] - base) < 10000; cyc++) begin
            @(posedge clk); #1;
            rst_n     = (cyc != 3000);
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = rand_opnd();
            b         = rand_opnd();
            tag       = 5'($urandom);
        end
        check("random_ops_done", 64'((n_acc[0] - base) >= 10000), 64'd1);

        @(posedge clk); #1;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("drain_empty_dut%0d", k), 64'(sb_q[k].size()), 64'd0);
            check($sformatf("drain_valid_dut%0d", k), 64'(out_valid_v[k]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
